// File: rtl/usb_tx_line_encoder.sv
// usb_tx_line_encoder: bit stuffing, NRZI encoding and EOP generation for the USB transmit line.
// Ports: clock (bit-time clock), reset_n (sync, active-low),
//        bit_in/bit_valid/bit_last/bit_ready (raw packet bit handshake),
//        DP_out/DM_out (line levels), sending (tristate enable),
//        pkt_done (pulse on normal completion), underrun (pulse on abort).
module usb_tx_line_encoder #(
    parameter int STUFF_LEN    = 6,
    parameter int EOP_SE0_BITS = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic bit_in,
    input  logic bit_valid,
    input  logic bit_last,
    output logic bit_ready,
    output logic DP_out,
    output logic DM_out,
    output logic sending,
    output logic pkt_done,
    output logic underrun
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SEND    = 3'd1;
    localparam logic [2:0] S_STUFF   = 3'd2;
    localparam logic [2:0] S_EOP_SE0 = 3'd3;
    localparam logic [2:0] S_EOP_J   = 3'd4;
    localparam int CW = $clog2(STUFF_LEN + 1);
    localparam int EW = $clog2(EOP_SE0_BITS + 1);
    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [EW-1:0] r_se0;
    logic          r_last, r_abort, r_dp, r_dm, r_sending, r_done, r_under;
    logic          w_xfer, w_ref, w_dp, w_stuff, w_se0_end;
    logic [CW-1:0] w_base, w_cnt;
    // Each state's line action is registered on the edge that leaves it,
    // so every level shows on the bus the cycle after it is decided.
    // A new packet always encodes against J with a cleared stuff count.
    assign w_ref     = (r_state == S_IDLE) ? 1'b1 : r_dp;
    assign w_base    = (r_state == S_IDLE) ? '0 : r_cnt;
    assign w_dp      = bit_in ? w_ref : ~w_ref;
    assign w_cnt     = bit_in ? w_base + CW'(1) : '0;
    assign w_stuff   = (w_cnt == CW'(STUFF_LEN));
    assign w_se0_end = (r_se0 == EW'(EOP_SE0_BITS - 1));
    assign bit_ready = reset_n && (r_state == S_IDLE || r_state == S_SEND);
    assign w_xfer    = bit_valid && bit_ready;
    assign DP_out    = r_dp;
    assign DM_out    = r_dm;
    assign sending   = r_sending;
    assign pkt_done  = r_done;
    assign underrun  = r_under;
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_se0     <= '0;
            r_last    <= 1'b0;
            r_abort   <= 1'b0;
            r_dp      <= 1'b1;
            r_dm      <= 1'b0;
            r_sending <= 1'b0;
            r_done    <= 1'b0;
            r_under   <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_under <= 1'b0;
            case (r_state)
                S_IDLE, S_SEND: begin
                    if (w_xfer) begin
                        r_dp      <= w_dp;
                        r_dm      <= ~w_dp;
                        r_sending <= 1'b1;
                        r_cnt     <= w_cnt;
                        r_last    <= bit_last;
                        r_state   <= w_stuff ? S_STUFF : (bit_last ? S_EOP_SE0 : S_SEND);
                    end else if (r_state == S_SEND) begin
                        // Starved mid-packet: hold the line and close with an EOP.
                        r_under <= 1'b1;
                        r_abort <= 1'b1;
                        r_state <= S_EOP_SE0;
                    end else begin
                        r_dp      <= 1'b1;
                        r_dm      <= 1'b0;
                        r_sending <= 1'b0;
                        r_cnt     <= '0;
                    end
                end
                S_STUFF: begin
                    r_dp    <= ~r_dp;
                    r_dm    <= r_dp;
                    r_cnt   <= '0;
                    r_state <= r_last ? S_EOP_SE0 : S_SEND;
                end
                S_EOP_SE0: begin
                    r_dp    <= 1'b0;
                    r_dm    <= 1'b0;
                    r_se0   <= w_se0_end ? '0 : r_se0 + EW'(1);
                    r_state <= w_se0_end ? S_EOP_J : S_EOP_SE0;
                end
                S_EOP_J: begin
                    r_dp    <= 1'b1;
                    r_dm    <= 1'b0;
                    r_done  <= ~r_abort;
                    r_abort <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_usb_tx_line_encoder.sv
// tb_usb_tx_line_encoder: cycle-by-cycle vector table plus a back-to-back packet sequence.
module tb_usb_tx_line_encoder;
    logic clock = 1'b0;
    logic reset_n, bit_in, bit_valid, bit_last;
    logic bit_ready, DP_out, DM_out, sending, pkt_done, underrun;
    int   errors = 0;
    int   checks = 0;
    localparam logic [1:0] J = 2'b10;
    localparam logic [1:0] K = 2'b01;
    localparam logic [1:0] S = 2'b00;
    typedef struct {
        logic       r, v, b, l;
        logic [5:0] exp;
    } vec_t;
    vec_t vecs[$];
    usb_tx_line_encoder dut (
        .clock(clock), .reset_n(reset_n), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_last(bit_last), .bit_ready(bit_ready), .DP_out(DP_out), .DM_out(DM_out),
        .sending(sending), .pkt_done(pkt_done), .underrun(underrun)
    );
    always #5 clock = ~clock;
    task automatic add(input logic r, v, b, l, rdy, input logic [1:0] ln, input logic snd, done, und);
        vecs.push_back('{r: r, v: v, b: b, l: l, exp: {rdy, ln, snd, done, und}});
    endtask
    task automatic chk(input string name, input int idx, input logic [5:0] got, input logic [5:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got {rdy,dp,dm,snd,done,und}=%b expected %b", name, idx, got, exp);
        end
    endtask
    function automatic logic [5:0] outs();
        return {bit_ready, DP_out, DM_out, sending, pkt_done, underrun};
    endfunction
    initial begin
        int n;
        int dones;
        reset_n = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; bit_last = 1'b0;
        // reset state
        add(0,0,0,0, 0,J,0,0,0);
        add(1,0,0,0, 1,J,0,0,0);
        // SYNC 0000_0001 then trailing 0 with last
        add(1,1,0,0, 1,J,0,0,0);
        add(1,1,0,0, 1,K,1,0,0);
        add(1,1,0,0, 1,J,1,0,0);
        add(1,1,0,0, 1,K,1,0,0);
        add(1,1,0,0, 1,J,1,0,0);
        add(1,1,0,0, 1,K,1,0,0);
        add(1,1,0,0, 1,J,1,0,0);
        add(1,1,1,0, 1,K,1,0,0);
        add(1,1,0,1, 1,K,1,0,0);
        add(1,1,1,0, 0,J,1,0,0);
        add(1,1,1,0, 0,S,1,0,0);
        add(1,1,1,0, 0,S,1,0,0);
        add(1,0,1,1, 1,J,1,1,0);
        add(1,0,0,1, 1,J,0,0,0);
        // SYNC then seven 1s: stuff after the sixth consecutive 1
        add(1,1,0,0, 1,J,0,0,0);
        add(1,1,0,0, 1,K,1,0,0);
        add(1,1,0,0, 1,J,1,0,0);
        add(1,1,0,0, 1,K,1,0,0);
        add(1,1,0,0, 1,J,1,0,0);
        add(1,1,0,0, 1,K,1,0,0);
        add(1,1,0,0, 1,J,1,0,0);
        add(1,1,1,0, 1,K,1,0,0);
        for (int i = 0; i < 5; i++) add(1,1,1,0, 1,K,1,0,0);
        add(1,1,1,0, 0,K,1,0,0);
        add(1,1,1,0, 1,J,1,0,0);
        add(1,1,1,1, 1,J,1,0,0);
        add(1,0,0,0, 0,J,1,0,0);
        add(1,0,0,0, 0,S,1,0,0);
        add(1,0,0,0, 0,S,1,0,0);
        add(1,0,0,0, 1,J,1,1,0);
        add(1,0,0,0, 1,J,0,0,0);
        // packet ending on its sixth 1: stuff before the EOP
        add(1,1,0,0, 1,J,0,0,0);
        for (int i = 0; i < 5; i++) add(1,1,1,0, 1,K,1,0,0);
        add(1,1,1,1, 1,K,1,0,0);
        add(1,0,0,0, 0,K,1,0,0);
        add(1,0,0,0, 0,J,1,0,0);
        add(1,0,0,0, 0,S,1,0,0);
        add(1,0,0,0, 0,S,1,0,0);
        add(1,0,0,0, 1,J,1,1,0);
        add(1,0,0,0, 1,J,0,0,0);
        // underrun mid-payload; bits offered during EOP are refused
        add(1,1,0,0, 1,J,0,0,0);
        add(1,1,0,0, 1,K,1,0,0);
        add(1,1,1,0, 1,J,1,0,0);
        add(1,0,0,0, 1,J,1,0,0);
        add(1,1,0,0, 0,J,1,0,1);
        add(1,1,0,0, 0,S,1,0,0);
        add(1,1,0,0, 0,S,1,0,0);
        add(1,0,0,0, 1,J,1,0,0);
        add(1,0,0,0, 1,J,0,0,0);
        // reset mid-packet, then six 1s from a clean count and J reference
        add(1,1,0,0, 1,J,0,0,0);
        add(1,1,1,0, 1,K,1,0,0);
        add(0,1,0,0, 0,K,1,0,0);
        add(1,1,1,0, 1,J,0,0,0);
        for (int i = 0; i < 4; i++) add(1,1,1,0, 1,J,1,0,0);
        add(1,1,1,1, 1,J,1,0,0);
        add(1,0,0,0, 0,J,1,0,0);
        add(1,0,0,0, 0,K,1,0,0);
        add(1,0,0,0, 0,S,1,0,0);
        add(1,0,0,0, 0,S,1,0,0);
        add(1,0,0,0, 1,J,1,1,0);
        add(1,0,0,0, 1,J,0,0,0);
        repeat (2) @(negedge clock);
        foreach (vecs[i]) begin
            reset_n = vecs[i].r; bit_valid = vecs[i].v; bit_in = vecs[i].b; bit_last = vecs[i].l;
            #1;
            chk("vec", i, outs(), vecs[i].exp);
            @(negedge clock);
        end
        // back-to-back: packet 0,0(last) then single-bit packet 1(last), valid held high
        bit_valid = 1'b1; bit_in = 1'b0; bit_last = 1'b0;
        @(negedge clock);
        bit_last = 1'b1;
        @(negedge clock);
        bit_in = 1'b1;
        n = 0;
        while (!bit_ready && n < 10) begin
            @(negedge clock);
            n++;
        end
        chk("b2b_wait", n, {2'b00, 4'(n)}, 6'd3);
        chk("b2b_accept", 0, outs(), {1'b1, J, 1'b1, 1'b1, 1'b0});
        @(negedge clock);
        bit_valid = 1'b0;
        #1;
        chk("b2b_first", 0, outs(), {1'b0, J, 1'b1, 1'b0, 1'b0});
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            dones += int'(pkt_done);
        end
        chk("b2b_done2", dones, {2'b00, 4'(dones)}, 6'd1);
        chk("b2b_idle", 0, outs(), {1'b1, J, 1'b0, 1'b0, 1'b0});
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
